// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port word memory between the CPU instruction-fetch port
// (i_*) and the CPU data-access port (d_*). Data has fixed priority, but a
// starvation counter forces an instruction grant after STARVE_LIMIT
// consecutive data grants that were taken while a fetch was pending.
//
// Handshake (both requester ports): the requester raises x_req and holds its
// address / write data / byte enables stable until x_ready. x_ready is a
// single-cycle completion pulse; x_rdata is valid with it on reads and holds
// its value afterwards. The memory side sees exactly one m_en cycle per
// transaction; m_rdata is expected MEM_LATENCY cycles after that strobe
// (0 = combinational, valid in the m_en cycle itself).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_req/i_addr        fetch request and byte address
//   i_ready/i_rdata     fetch completion pulse and fetched word
//   d_req/d_addr        data request and byte address
//   d_wdata/d_wen       store data and byte enables (d_wen == 0 -> load)
//   d_ready/d_rdata     data completion pulse and load word
//   m_en/m_addr         memory strobe and latched address
//   m_wdata/m_wen       memory write data and byte enables (gated by m_en)
//   m_rdata             memory read data
//   busy                high whenever the FSM is not IDLE
//   o_dbg_state         current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   o_dbg_starve_cnt    current starvation counter
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ready,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wen,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_en,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wen,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  busy,
    output logic [1:0]            o_dbg_state,
    output logic [3:0]            o_dbg_starve_cnt
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_owner_d;     // 1: data port owns the transaction
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_wen;
    logic [2:0]          r_lat_cnt;
    logic [3:0]          r_starve_cnt;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic                w_grant_d;
    logic                w_grant_i;
    logic                w_sample;      // capture m_rdata into the owner's register
    logic                w_is_write;
    logic                w_starved;

    assign w_is_write = (r_wen != '0);
    assign w_starved  = i_req && (r_starve_cnt == STARVE_MAX);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state, arbitration and strobe decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        w_sample    = 1'b0;
        m_en        = 1'b0;
        i_ready     = 1'b0;
        d_ready     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Data wins unless the fetch side has been passed over
                // STARVE_LIMIT times in a row.
                if (d_req && !w_starved) begin
                    w_grant_d = 1'b1;
                end else if (i_req) begin
                    w_grant_i = 1'b1;
                end
                if (w_grant_d || w_grant_i) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_en = 1'b1;
                if (w_is_write || (MEM_LATENCY == 0)) begin
                    w_sample    = !w_is_write;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Counter value 1 marks the cycle exactly MEM_LATENCY cycles
                // after the strobe; <= guards against a stuck zero.
                if (r_lat_cnt <= 3'd1) begin
                    w_sample    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                i_ready     = !r_owner_d;
                d_ready     = r_owner_d;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch, latency / starvation counters, read-data capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner_d    <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wen        <= '0;
            r_lat_cnt    <= 3'd0;
            r_starve_cnt <= 4'd0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner_d <= 1'b1;
                r_addr    <= d_addr;
                r_wdata   <= d_wdata;
                r_wen     <= d_wen;
                if (i_req && (r_starve_cnt != STARVE_MAX)) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else if (w_grant_i) begin
                r_owner_d    <= 1'b0;
                r_addr       <= i_addr;
                r_wdata      <= '0;
                r_wen        <= '0;
                r_starve_cnt <= 4'd0;
            end

            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= LAT_INIT;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end

            if (w_sample) begin
                if (r_owner_d) begin
                    r_d_rdata <= m_rdata;
                end else begin
                    r_i_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_addr           = r_addr;
    assign m_wdata          = r_wdata;
    assign m_wen            = m_en ? r_wen : '0;
    assign i_rdata          = r_i_rdata;
    assign d_rdata          = r_d_rdata;
    assign busy             = (r_state != ST_IDLE);
    assign o_dbg_state      = r_state;
    assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances share one clock and reset: dut0 with combinational
// memory (MEM_LATENCY=0) and dut2 with MEM_LATENCY=2. A small word memory
// answers both; its read data is only meaningful in the exact cycle the
// arbiter is supposed to sample it, elsewhere it returns a poison word.
// Expected read words are pushed to exp_q when a request is driven and
// popped when the matching ready pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    // ------------------------------------------------------------ dut0 (L=0)
    logic        i0_req, d0_req, i0_ready, d0_ready, m0_en, busy0;
    logic [31:0] i0_addr, d0_addr, d0_wdata, i0_rdata, d0_rdata;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  d0_wen, m0_wen, cnt0;
    logic [1:0]  st0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(0), .STARVE_LIMIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i0_req), .i_addr(i0_addr), .i_ready(i0_ready), .i_rdata(i0_rdata),
        .d_req(d0_req), .d_addr(d0_addr), .d_wdata(d0_wdata), .d_wen(d0_wen),
        .d_ready(d0_ready), .d_rdata(d0_rdata),
        .m_en(m0_en), .m_addr(m0_addr), .m_wdata(m0_wdata), .m_wen(m0_wen),
        .m_rdata(m0_rdata), .busy(busy0),
        .o_dbg_state(st0), .o_dbg_starve_cnt(cnt0)
    );

    // ------------------------------------------------------------ dut2 (L=2)
    logic        i2_req, d2_req, i2_ready, d2_ready, m2_en, busy2;
    logic [31:0] i2_addr, d2_addr, d2_wdata, i2_rdata, d2_rdata;
    logic [31:0] m2_addr, m2_wdata, m2_rdata;
    logic [3:0]  d2_wen, m2_wen, cnt2;
    logic [1:0]  st2;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i2_req), .i_addr(i2_addr), .i_ready(i2_ready), .i_rdata(i2_rdata),
        .d_req(d2_req), .d_addr(d2_addr), .d_wdata(d2_wdata), .d_wen(d2_wen),
        .d_ready(d2_ready), .d_rdata(d2_rdata),
        .m_en(m2_en), .m_addr(m2_addr), .m_wdata(m2_wdata), .m_wen(m2_wen),
        .m_rdata(m2_rdata), .busy(busy2),
        .o_dbg_state(st2), .o_dbg_starve_cnt(cnt2)
    );

    // ------------------------------------------------------------ memory model
    logic [31:0] mem [0:255];
    logic        en2_d1 = 1'b0;
    logic        en2_d2 = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[4] <= 32'h0050_0093;
        end else if (m0_en) begin
            for (int b = 0; b < 4; b++) begin
                if (m0_wen[b]) mem[m0_addr[9:2]][b*8 +: 8] <= m0_wdata[b*8 +: 8];
            end
        end
        en2_d1 <= m2_en;
        en2_d2 <= en2_d1;
    end

    assign m0_rdata = m0_en  ? mem[m0_addr[9:2]] : POISON;
    assign m2_rdata = en2_d2 ? mem[m2_addr[9:2]] : POISON;

    // ------------------------------------------------------------ scoreboard
    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // which: 0=dut0 fetch, 1=dut0 data, 2=dut2 fetch, 3=dut2 data
    task automatic wait_rdy(input int which, input string tag, input bit is_read, input int exp_cyc);
        bit          seen;
        logic        rdy;
        logic [31:0] rd;
        logic [31:0] exp_v;
        seen = 1'b0;
        rd   = '0;
        for (int k = 0; k < 16 && !seen; k++) begin
            step();
            case (which)
                0: rdy = i0_ready;
                1: rdy = d0_ready;
                2: rdy = i2_ready;
                default: rdy = d2_ready;
            endcase
            if (rdy === 1'b1) seen = 1'b1;
        end
        chk({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            chk({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
            case (which)
                0: begin rd = i0_rdata; i0_req = 1'b0; end
                1: begin rd = d0_rdata; d0_req = 1'b0; end
                2: begin rd = i2_rdata; i2_req = 1'b0; end
                default: begin rd = d2_rdata; d2_req = 1'b0; end
            endcase
            if (is_read) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL %s_queue observed=ready expected=pending entry", tag);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk({tag, "_rdata"}, 64'(rd), 64'(exp_v));
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int   t0;
        bit   gnt_d;
        bit   seen;
        bit   exp_gnt [6];
        logic [3:0] exp_cnt [6];

        exp_gnt = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1};

        i0_req = 0; i0_addr = '0; d0_req = 0; d0_addr = '0; d0_wdata = '0; d0_wen = '0;
        i2_req = 0; i2_addr = '0; d2_req = 0; d2_addr = '0; d2_wdata = '0; d2_wen = '0;

        // Reset state
        step(); step();
        chk("rst_i_ready", 64'(i0_ready), 0);
        chk("rst_d_ready", 64'(d0_ready), 0);
        chk("rst_m_en",    64'(m0_en),    0);
        chk("rst_m_addr",  64'(m0_addr),  0);
        chk("rst_m_wdata", 64'(m0_wdata), 0);
        chk("rst_m_wen",   64'(m0_wen),   0);
        chk("rst_busy",    64'(busy0),    0);
        chk("rst_i_rdata", 64'(i0_rdata), 0);
        chk("rst_d_rdata", 64'(d0_rdata), 0);
        chk("rst_busy2",   64'(busy2),    0);
        rst_n = 1'b1;
        step();

        // Single fetch, combinational memory
        i0_req = 1; i0_addr = 32'h10; t0 = cyc;
        exp_q.push_back(32'h0050_0093);
        step();
        chk("fetch_m_en",   64'(m0_en),   1);
        chk("fetch_m_addr", 64'(m0_addr), 64'h10);
        chk("fetch_m_wen",  64'(m0_wen),  0);
        chk("fetch_busy1",  64'(busy0),   1);
        wait_rdy(0, "fetch", 1'b1, t0 + 2);
        chk("fetch_busy2", 64'(busy0), 1);
        step();
        chk("fetch_idle", 64'(busy0), 0);

        // Store then load
        d0_req = 1; d0_addr = 32'h100; d0_wdata = 32'hDEAD_BEEF; d0_wen = 4'hF; t0 = cyc;
        step();
        chk("store_m_en",    64'(m0_en),    1);
        chk("store_m_wen",   64'(m0_wen),   64'hF);
        chk("store_m_wdata", 64'(m0_wdata), 64'hDEAD_BEEF);
        wait_rdy(1, "store", 1'b0, t0 + 2);
        chk("store_d_rdata", 64'(d0_rdata), 0);
        chk("store_wen_off", 64'(m0_wen),   0);
        step();
        d0_req = 1; d0_addr = 32'h100; d0_wdata = '0; d0_wen = 4'h0; t0 = cyc;
        exp_q.push_back(32'hDEAD_BEEF);
        wait_rdy(1, "load", 1'b1, t0 + 2);
        step();

        // Simultaneous requests, counter at 0: data first
        d0_req = 1; d0_addr = 32'h100; d0_wen = 4'h0;
        i0_req = 1; i0_addr = 32'h14; t0 = cyc;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hA500_0005);
        wait_rdy(1, "sim_d", 1'b1, t0 + 2);
        chk("sim_i_wait", 64'(i0_ready), 0);
        wait_rdy(0, "sim_i", 1'b1, t0 + 5);
        chk("sim_cnt", 64'(cnt0), 0);
        step();

        // Starvation guard: both held continuously
        d0_req = 1; d0_addr = 32'h104; d0_wen = 4'h0;
        i0_req = 1; i0_addr = 32'h18;
        for (int g = 0; g < 6; g++) begin
            seen  = 1'b0;
            gnt_d = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                step();
                if (d0_ready === 1'b1 || i0_ready === 1'b1) begin
                    seen  = 1'b1;
                    gnt_d = d0_ready;
                end
            end
            chk($sformatf("starve_seen%0d", g), 64'(seen),  1);
            chk($sformatf("starve_gnt%0d", g),  64'(gnt_d), 64'(exp_gnt[g]));
            chk($sformatf("starve_cnt%0d", g),  64'(cnt0),  64'(exp_cnt[g]));
        end
        d0_req = 0; i0_req = 0;
        step();

        // MEM_LATENCY=2 data read
        d2_req = 1; d2_addr = 32'h20; t0 = cyc;
        exp_q.push_back(32'hA500_0008);
        step();
        chk("lat2_m_en1", 64'(m2_en), 1);
        step();
        chk("lat2_m_en2",   64'(m2_en),   0);
        chk("lat2_m_wen2",  64'(m2_wen),  0);
        chk("lat2_m_addr2", 64'(m2_addr), 64'h20);
        chk("lat2_busy2",   64'(busy2),   1);
        step();
        chk("lat2_m_en3",  64'(m2_en),    0);
        chk("lat2_ready3", 64'(d2_ready), 0);
        wait_rdy(3, "lat2_rd", 1'b1, t0 + 4);
        step();

        // Reset while in WAIT
        i2_req = 1; i2_addr = 32'h10;
        step();
        step();
        chk("rstw_state", 64'(st2), 2);
        rst_n = 1'b0;
        step();
        chk("rstw_i_ready", 64'(i2_ready), 0);
        chk("rstw_m_en",    64'(m2_en),    0);
        chk("rstw_m_addr",  64'(m2_addr),  0);
        chk("rstw_busy",    64'(busy2),    0);
        chk("rstw_d_rdata", 64'(d2_rdata), 0);
        chk("rstw_cnt0",    64'(cnt0),     0);
        rst_n  = 1'b1;
        i2_req = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rstw_quiet_rdy%0d", k), 64'(i2_ready), 0);
            chk($sformatf("rstw_quiet_en%0d", k),  64'(m2_en),    0);
        end

        // Fetch after reset release
        i2_req = 1; i2_addr = 32'h10; t0 = cyc;
        exp_q.push_back(32'h0050_0093);
        wait_rdy(2, "post_rst", 1'b1, t0 + 4);
        step();
        chk("final_queue_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
